// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control path: per-stage control words,
// bubble constants, ALUop and opcode encodings shared with the decoder.
package mips_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;

  typedef struct packed {
    logic       regdst;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
    logic [4:0] dst;
  } ex_ctrl_t;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] dst;
  } mem_ctrl_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] dst;
  } wb_ctrl_t;

  localparam int EX_CTRL_W  = $bits(ex_ctrl_t);
  localparam int MEM_CTRL_W = $bits(mem_ctrl_t);
  localparam int WB_CTRL_W  = $bits(wb_ctrl_t);

  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

  // Non-writing instructions (sw, beq) leave regdst undefined; regwrite gates it first.
  function automatic logic [4:0] resolve_dst(input logic       regwrite,
                                             input logic       regdst,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd);
    logic [4:0] dst;
    dst = 5'd0;
    if (regwrite) begin
      dst = regdst ? rd : rt;
    end
    return dst;
  endfunction

  function automatic mem_ctrl_t ex_to_mem(input ex_ctrl_t ex);
    mem_ctrl_t m;
    m.memread  = ex.memread;
    m.memwrite = ex.memwrite;
    m.regwrite = ex.regwrite;
    m.memtoreg = ex.memtoreg;
    m.dst      = ex.dst;
    return m;
  endfunction

  function automatic wb_ctrl_t mem_to_wb(input mem_ctrl_t mem);
    wb_ctrl_t w;
    w.regwrite = mem.regwrite;
    w.memtoreg = mem.memtoreg;
    w.dst      = mem.dst;
    return w;
  endfunction

endpackage

// File: rtl/mips_ctrl_pipe_if.sv
// Bus between the ID stage / datapath (master) and the control pipeline (slave).
interface mips_ctrl_pipe_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_regdst;
  logic             id_branch;
  logic             id_memread;
  logic             id_memtoreg;
  logic             id_memwrite;
  logic             id_alusrc;
  logic             id_regwrite;
  logic [1:0]       id_aluop;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             ex_zero;

  logic             ex_alusrc;
  logic             ex_regdst;
  logic [1:0]       ex_aluop;
  logic             mem_memread;
  logic             mem_memwrite;
  logic             wb_regwrite;
  logic             wb_memtoreg;
  logic [4:0]       wb_dst;
  logic             stall;
  logic             pc_src;
  logic             flush_if_id;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_regdst, id_branch, id_memread, id_memtoreg, id_memwrite,
           id_alusrc, id_regwrite, id_aluop, id_rs, id_rt, id_rd, ex_zero,
    input  ex_alusrc, ex_regdst, ex_aluop, mem_memread, mem_memwrite,
           wb_regwrite, wb_memtoreg, wb_dst, stall, pc_src, flush_if_id,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_regdst, id_branch, id_memread, id_memtoreg, id_memwrite,
           id_alusrc, id_regwrite, id_aluop, id_rs, id_rt, id_rd, ex_zero,
    output ex_alusrc, ex_regdst, ex_aluop, mem_memread, mem_memwrite,
           wb_regwrite, wb_memtoreg, wb_dst, stall, pc_src, flush_if_id,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/mips_ctrl_stage_reg.sv
// One pipeline control register: resets to the bubble value and can load a bubble
// instead of its input on any edge.
module mips_ctrl_stage_reg #(
  parameter int           W      = 8,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = bubble_i ? BUBBLE : d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= BUBBLE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mips_ctrl_pipe.sv
// Control-word pipeline ID->EX->MEM->WB with load-use stall, taken-branch flush
// and saturating stall/flush event counters.
module mips_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  mips_ctrl_pipe_if.slave bus
);

  ex_ctrl_t  ex_d;
  ex_ctrl_t  ex_q;
  mem_ctrl_t mem_d;
  mem_ctrl_t mem_q;
  wb_ctrl_t  wb_d;
  wb_ctrl_t  wb_q;

  logic load_use;
  logic br_taken;
  logic ex_bubble;
  logic stall_evt;

  // Decoder bits are cleaned before capture so undefined fields never enter the pipe.
  always_comb begin
    ex_d          = EX_BUBBLE;
    ex_d.regdst   = bus.id_regwrite & bus.id_regdst;
    ex_d.branch   = bus.id_branch;
    ex_d.memread  = bus.id_memread;
    ex_d.memtoreg = bus.id_memtoreg;
    ex_d.memwrite = bus.id_memwrite;
    ex_d.alusrc   = bus.id_alusrc;
    ex_d.regwrite = bus.id_regwrite;
    ex_d.aluop    = bus.id_aluop;
    ex_d.dst      = resolve_dst(bus.id_regwrite, bus.id_regdst, bus.id_rt, bus.id_rd);
  end

  // A load's rt is its destination, so only rs is compared when ID holds a load.
  always_comb begin
    load_use = ex_q.memread & (ex_q.dst != 5'd0) & bus.id_valid &
               ((ex_q.dst == bus.id_rs) | ((ex_q.dst == bus.id_rt) & ~bus.id_memread));
    br_taken  = ex_q.branch & bus.ex_zero;
    stall_evt = load_use & ~br_taken;
    ex_bubble = load_use | br_taken | ~bus.id_valid;
  end

  always_comb begin
    mem_d = ex_to_mem(ex_q);
    wb_d  = mem_to_wb(mem_q);
  end

  mips_ctrl_stage_reg #(
    .W      (EX_CTRL_W),
    .BUBBLE (EX_BUBBLE)
  ) u_ex_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (ex_bubble),
    .d_i      (ex_d),
    .q_o      (ex_q)
  );

  mips_ctrl_stage_reg #(
    .W      (MEM_CTRL_W),
    .BUBBLE (MEM_BUBBLE)
  ) u_mem_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (1'b0),
    .d_i      (mem_d),
    .q_o      (mem_q)
  );

  mips_ctrl_stage_reg #(
    .W      (WB_CTRL_W),
    .BUBBLE (WB_BUBBLE)
  ) u_wb_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (1'b0),
    .d_i      (wb_d),
    .q_o      (wb_q)
  );

  // Event counters: index 0 counts stall cycles, index 1 counts taken branches.
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       cnt_evt;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign cnt_evt = {br_taken, stall_evt};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (cnt_evt[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
          cnt_d[gi] = cnt_q[gi] + CNT_ONE;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  assign bus.ex_alusrc    = ex_q.alusrc;
  assign bus.ex_regdst    = ex_q.regdst;
  assign bus.ex_aluop     = ex_q.aluop;
  assign bus.mem_memread  = mem_q.memread;
  assign bus.mem_memwrite = mem_q.memwrite;
  assign bus.wb_regwrite  = wb_q.regwrite;
  assign bus.wb_memtoreg  = wb_q.memtoreg;
  assign bus.wb_dst       = wb_q.dst;
  assign bus.stall        = stall_evt;
  assign bus.pc_src       = br_taken;
  assign bus.flush_if_id  = br_taken;
  assign bus.stall_cnt    = cnt_q[0];
  assign bus.flush_cnt    = cnt_q[1];

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Directed bench for mips_ctrl_pipe: pass-through latency, load-use stall, branch
// flush, priority, counter saturation (narrow counters) and async reset mid-stall.
module tb_mips_ctrl_pipe;

  localparam int CNT_W = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mips_ctrl_pipe_if #(.CNT_W(CNT_W)) bus ();

  mips_ctrl_pipe #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic regdst, input logic branch,
                           input logic memread, input logic memtoreg, input logic memwrite,
                           input logic alusrc, input logic regwrite, input logic [1:0] aluop,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.id_valid    = v;
    bus.id_regdst   = regdst;
    bus.id_branch   = branch;
    bus.id_memread  = memread;
    bus.id_memtoreg = memtoreg;
    bus.id_memwrite = memwrite;
    bus.id_alusrc   = alusrc;
    bus.id_regwrite = regwrite;
    bus.id_aluop    = aluop;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rd;
  endtask

  task automatic set_idle();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic set_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    set_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, rs, rt, rd);
  endtask

  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, rs, rt, 5'd0);
  endtask

  task automatic set_sw(input logic [4:0] rs, input logic [4:0] rt);
    set_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, rs, rt, 5'd0);
  endtask

  task automatic set_beq(input logic [4:0] rs, input logic [4:0] rt);
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, rs, rt, 5'd0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.ex_zero = 1'b0;
    set_idle();

    // Reset state
    #12;
    check_eq("rst_stall", bus.stall, 0);
    check_eq("rst_pc_src", bus.pc_src, 0);
    check_eq("rst_wb_dst", bus.wb_dst, 0);
    check_eq("rst_stall_cnt", bus.stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through of an R-type, rd=5
    set_r(5'd1, 5'd2, 5'd5);
    tick();
    set_idle();
    check_eq("pt_ex_aluop", bus.ex_aluop, 2'b10);
    check_eq("pt_ex_regdst", bus.ex_regdst, 1);
    tick();
    check_eq("pt_mem_memread", bus.mem_memread, 0);
    check_eq("pt_ex_aluop_bubble", bus.ex_aluop, 0);
    tick();
    check_eq("pt_wb_regwrite", bus.wb_regwrite, 1);
    check_eq("pt_wb_dst", bus.wb_dst, 5);
    check_eq("pt_wb_memtoreg", bus.wb_memtoreg, 0);
    tick();

    // Load-use on rs
    set_lw(5'd1, 5'd8);
    tick();
    check_eq("lu_ex_alusrc_lw", bus.ex_alusrc, 1);
    set_r(5'd8, 5'd9, 5'd10);
    #1;
    check_eq("lu_stall", bus.stall, 1);
    check_eq("lu_pc_src", bus.pc_src, 0);
    tick();
    check_eq("lu_ex_aluop_bubble", bus.ex_aluop, 0);
    check_eq("lu_ex_regdst_bubble", bus.ex_regdst, 0);
    check_eq("lu_stall_cnt", bus.stall_cnt, 1);
    check_eq("lu_stall_cleared", bus.stall, 0);
    check_eq("lu_mem_memread", bus.mem_memread, 1);
    tick();
    check_eq("lu_add_enters_ex", bus.ex_aluop, 2'b10);
    set_idle();
    tick();

    // Load with rt=0 never stalls
    set_lw(5'd1, 5'd0);
    tick();
    set_r(5'd0, 5'd0, 5'd3);
    #1;
    check_eq("lu0_stall", bus.stall, 0);
    tick();
    check_eq("lu0_stall_cnt", bus.stall_cnt, 1);
    set_idle();
    tick();

    // lw after lw: rt compare excluded; sw with the same rt does stall
    set_lw(5'd1, 5'd8);
    tick();
    set_lw(5'd3, 5'd8);
    #1;
    check_eq("lwlw_stall", bus.stall, 0);
    set_sw(5'd3, 5'd8);
    #1;
    check_eq("lwsw_stall", bus.stall, 1);
    tick();
    check_eq("lwsw_stall_cnt", bus.stall_cnt, 2);
    set_idle();
    tick();
    tick();

    // beq taken
    set_beq(5'd1, 5'd2);
    tick();
    bus.ex_zero = 1'b1;
    set_r(5'd4, 5'd5, 5'd6);
    #1;
    check_eq("bt_pc_src", bus.pc_src, 1);
    check_eq("bt_flush", bus.flush_if_id, 1);
    check_eq("bt_stall", bus.stall, 0);
    tick();
    check_eq("bt_ex_aluop_bubble", bus.ex_aluop, 0);
    check_eq("bt_ex_regdst_bubble", bus.ex_regdst, 0);
    check_eq("bt_flush_cnt", bus.flush_cnt, 1);
    check_eq("bt_pc_src_after", bus.pc_src, 0);
    bus.ex_zero = 1'b0;
    set_idle();
    tick();

    // beq not taken
    set_beq(5'd1, 5'd2);
    tick();
    check_eq("bn_ex_aluop_sub", bus.ex_aluop, 2'b01);
    set_r(5'd4, 5'd5, 5'd6);
    #1;
    check_eq("bn_pc_src", bus.pc_src, 0);
    check_eq("bn_flush", bus.flush_if_id, 0);
    tick();
    check_eq("bn_ex_aluop_r", bus.ex_aluop, 2'b10);
    check_eq("bn_flush_cnt", bus.flush_cnt, 1);
    set_idle();
    tick();

    // Taken branch and load-use together: branch wins
    set_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 5'd1, 5'd8, 5'd0);
    tick();
    set_r(5'd8, 5'd9, 5'd10);
    bus.ex_zero = 1'b0;
    #1;
    check_eq("sim_nt_stall", bus.stall, 1);
    bus.ex_zero = 1'b1;
    #1;
    check_eq("sim_stall", bus.stall, 0);
    check_eq("sim_pc_src", bus.pc_src, 1);
    tick();
    check_eq("sim_stall_cnt", bus.stall_cnt, 2);
    check_eq("sim_flush_cnt", bus.flush_cnt, 2);
    check_eq("sim_ex_bubble", bus.ex_aluop, 0);
    bus.ex_zero = 1'b0;
    set_idle();
    tick();

    // Stall counter saturation (all-ones = 7)
    for (int i = 0; i < 6; i++) begin
      set_lw(5'd1, 5'd8);
      tick();
      set_r(5'd8, 5'd9, 5'd10);
      tick();
      set_idle();
      if (i == 4) check_eq("sat_stall_cnt_max", bus.stall_cnt, 7);
    end
    check_eq("sat_stall_cnt_hold", bus.stall_cnt, 7);

    // Flush counter saturation
    for (int i = 0; i < 6; i++) begin
      set_beq(5'd1, 5'd2);
      tick();
      bus.ex_zero = 1'b1;
      set_idle();
      tick();
      bus.ex_zero = 1'b0;
      if (i == 4) check_eq("sat_flush_cnt_max", bus.flush_cnt, 7);
    end
    check_eq("sat_flush_cnt_hold", bus.flush_cnt, 7);
    tick();

    // Asynchronous reset in the middle of a load-use stall
    set_r(5'd1, 5'd2, 5'd5);
    tick();
    set_idle();
    tick();
    set_lw(5'd1, 5'd8);
    tick();
    check_eq("mr_pre_wb_dst", bus.wb_dst, 5);
    set_r(5'd8, 5'd9, 5'd10);
    #1;
    check_eq("mr_pre_stall", bus.stall, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_stall", bus.stall, 0);
    check_eq("mr_ex_alusrc", bus.ex_alusrc, 0);
    check_eq("mr_ex_aluop", bus.ex_aluop, 0);
    check_eq("mr_wb_regwrite", bus.wb_regwrite, 0);
    check_eq("mr_wb_dst", bus.wb_dst, 0);
    check_eq("mr_stall_cnt", bus.stall_cnt, 0);
    check_eq("mr_flush_cnt", bus.flush_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release captures ID normally
    set_r(5'd1, 5'd2, 5'd7);
    tick();
    check_eq("post_ex_aluop", bus.ex_aluop, 2'b10);
    set_idle();
    tick();
    tick();
    check_eq("post_wb_dst", bus.wb_dst, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_ctrl_pipe.md
# mips_ctrl_pipe

Carries the decoded control word from the ID stage to EX, MEM and WB through three pipeline register stages. Consumes the decoder's control bits and drives them to the datapath stages that use them. Detects load-use hazards and taken branches, and generates the stall, bubble and flush controls for the 5-stage MIPS pipeline. Sits directly downstream of the opcode decoder and beside the ID/EX, EX/MEM and MEM/WB datapath registers.

## Interface
- `CNT_W`, default 16: width of the saturating stall and flush event counters.
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  the ID stage holds a real instruction.
- `id_regdst`, `id_branch`, `id_memread`, `id_memtoreg`, `id_memwrite`, `id_alusrc`, `id_regwrite`  in  1 each  decoded control bits from the decoder.
- `id_aluop`  in  2  decoded ALUop: 00 add, 01 sub/compare, 10 funct-driven.
- `id_rs`, `id_rt`, `id_rd`  in  5 each  register fields of the ID instruction.
- `ex_zero`  in  1  ALU zero flag for the instruction currently in EX.
- `ex_alusrc`, `ex_regdst`  out  1 each  EX-stage controls.
- `ex_aluop`  out  2  EX-stage ALUop.
- `mem_memread`, `mem_memwrite`  out  1 each  MEM-stage controls.
- `wb_regwrite`, `wb_memtoreg`  out  1 each  WB-stage controls.
- `wb_dst`  out  5  destination register for write-back.
- `stall`  out  1  hold the PC and IF/ID this cycle.
- `pc_src`  out  1  select the branch target for the next PC.
- `flush_if_id`  out  1  zero IF/ID on the next edge.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating event counters.

## Operation
- EX stage register holds: regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop, dst.
- dst is resolved at the ID/EX edge: `id_regdst ? id_rd : id_rt`. It is forced to 0 when `id_regwrite=0`. X on `id_regdst` for sw/beq must never propagate.
- MEM stage register holds memread, memwrite, regwrite, memtoreg, dst.
- WB stage register holds regwrite, memtoreg, dst.
- A bubble is an all-zero control word with dst = 0.
- Load-use hazard: `ex_memread & (ex_dst != 0) & id_valid & (ex_dst == id_rs | (ex_dst == id_rt & ~id_memread))`. The rt compare is excluded for lw because rt is its destination.
- On a hazard: `stall=1`, and the ID/EX register loads a bubble. The EX→MEM→WB stages advance normally.
- Branch taken: `ex_branch & ex_zero`. Outputs are `pc_src=1` and `flush_if_id=1`, and the ID/EX register loads a bubble.
- Branch taken and hazard in the same cycle: the branch wins. `stall` is forced to 0 and the bubble is still inserted.
- `id_valid=0`: the ID/EX register loads a bubble, and no hazard is raised.
- `stall_cnt` increments once per stall cycle. `flush_cnt` increments once per taken branch. Both saturate at all-ones and never wrap.

## Timing
- Control word latency: ID→EX outputs 1 cycle, →MEM 2 cycles, →WB 3 cycles.
- `stall`, `pc_src` and `flush_if_id` are combinational from current EX state and ID inputs, and valid in the same cycle.
- A load-use stall lasts exactly 1 cycle per hazard, because the load advances to MEM and clears the condition.
- Reset (async assert, applied at any time, including mid-stall):
  - all stage registers go to a bubble;
  - all outputs go to 0: `stall`, `pc_src`, `flush_if_id`, `wb_dst`, and both counters.
- Reset release is synchronous to `clk`. The first edge after release captures ID normally.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - control-word struct typedef and the bubble constant;
  - ALUop encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10);
  - opcode constants R_TYPE=000000, LW=100011, SW=101011, BEQ=000100, shared with the decoder.
- Sub-module `mips_ctrl_stage_reg`: parameterised-width register with async active-low reset to the bubble value and a bubble-load input. It is instantiated three times.
- Hazard/branch logic and the counters live in the top module.

## Test plan
- Reset mid-stream: lw in EX with hazard active, assert `rst_n=0` → `stall=0`, all stage outputs 0, counters 0, asynchronously, without waiting for a clock edge.
- Pass-through: R-type (regwrite=1, regdst=1, aluop=10, rd=5) → `ex_aluop=10` at +1; `mem_memread=0` at +2; `wb_regwrite=1`, `wb_dst=5` at +3.
- Load-use on rs: lw rt=8 in EX, ID add rs=8 → `stall=1` for 1 cycle, `ex_*` zero next cycle, `stall_cnt=1`. Same case with rt=0 → no stall.
- lw after lw: ID lw with rt=8 behind EX lw dst=8 and id_rs=3 → no stall (rt compare excluded).
- beq taken: beq in EX with `ex_zero=1` → `pc_src=1`, `flush_if_id=1`, bubble in EX next cycle, `flush_cnt=1`. Same beq with `ex_zero=0` → none of these asserted.
- Simultaneous: taken branch plus load-use match in the same cycle → `stall=0`, `pc_src=1`. Separately, with counters preloaded to all-ones, one more event → counters stay all-ones.
